lsu_dm_master: RTL and testbench

LSU_DM_MASTER -- requirements
Module: lsu_dm_master

---
 rtl/lsu_dm_master.sv | 197 +++++++++++++++++++
 tb/tb_lsu_dm_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lsu_dm_master.sv
// lsu_dm_master
// Load/store unit front end for a word-wide data memory (128 words, byte
// addressed range 0x000-0x1FF). It accepts one CPU access at a time, checks
// alignment and range, and performs read-modify-write for byte and halfword
// stores. Loads return a sign- or zero-extended result.
//
// Ports
//   clk, rstn          : clock (rising edge), asynchronous active-low reset
//   req, we, size, uns : access request, store/load, size code, unsigned load
//   addr, wdata        : byte address, right-aligned store data
//   rdata              : extended load result, held until the next load
//   busy, done, err    : not-idle flag, one-cycle completion, reject flag
//   dm_addr, dm_we     : memory word index, word write enable
//   dm_din, dm_dout    : memory write word, combinational read word
module lsu_dm_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  // Only the in-range part of the address is kept; out-of-range accesses
  // are rejected before any memory cycle.
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        acc_err_s;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic        u,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = u ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = u ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the captured word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: r[{off, 3'b000} +: 8] = d[7:0];
      2'b01: begin
        if (off[1]) begin
          r[31:16] = d[15:0];
        end else begin
          r[15:0] = d[15:0];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Reject invalid size, misalignment and addresses beyond the memory.
  always_comb begin
    acc_err_s = 1'b0;
    if (addr[31:9] != 23'd0) begin
      acc_err_s = 1'b1;
    end else begin
      case (size)
        2'b00:   acc_err_s = 1'b0;
        2'b01:   acc_err_s = addr[0];
        2'b10:   acc_err_s = (addr[1:0] != 2'b00);
        default: acc_err_s = 1'b1;
      endcase
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr[8:0];
          wdata_d = wdata;
          err_d   = acc_err_s;
          if (acc_err_s) begin
            state_d = S_DONE;
          end else if (!we) begin
            state_d = S_RD;
          end else if (size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        word_d = dm_dout;
        if (we_q) begin
          state_d = S_WR;
        end else begin
          rdata_d = load_ext(dm_dout, size_q, uns_q, addr_q[1:0]);
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 9'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode directly from the state register, so an asynchronous
  // reset drops dm_we and busy immediately.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    err     = (state_q == S_DONE) ? err_q : 1'b0;
    dm_we   = (state_q == S_WR);
    dm_addr = ((state_q == S_RD) || (state_q == S_WR)) ? addr_q[8:2] : 7'd0;
    if (state_q == S_WR) begin
      dm_din = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
    end else begin
      dm_din = 32'd0;
    end
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_lsu_dm_master.sv
module tb_lsu_dm_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [6:0]  dm_addr;
  logic        dm_we;
  logic [31:0] dm_din, dm_dout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:127];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_idx = 7'd0;
  logic [31:0] pre_val = 32'd0;

  always #5 clk = ~clk;

  lsu_dm_master dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .dm_addr(dm_addr), .dm_we(dm_we), .dm_din(dm_din),
    .dm_dout(dm_dout)
  );

  // Data memory model: combinational read, commit on the falling edge.
  assign dm_dout = mem[dm_addr];
  always @(negedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (dm_we) mem[dm_addr] <= dm_din;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_en = 1'b1;
    @(negedge clk); #1;
    pre_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // One access from IDLE. With exp_we>0 the written word/index is checked,
  // otherwise rdata is checked against exp_val.
  task automatic run(input string tag, input logic we_i, input logic [1:0] sz_i,
                     input logic uns_i, input logic [31:0] a_i, input logic [31:0] d_i,
                     input int exp_lat, input int exp_we, input logic exp_err,
                     input logic [31:0] exp_val);
    int lat, wecnt;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic        e;
    lat = 0; wecnt = 0; wa = 7'd0; wd = 32'd0; e = 1'b0;
    req = 1'b1; we = we_i; size = sz_i; uns = uns_i; addr = a_i; wdata = d_i;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (dm_we) begin wecnt++; wa = dm_addr; wd = dm_din; end
      if (done) begin lat = n; e = err; break; end
      @(posedge clk); #1;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_we_cycles"}, wecnt, exp_we);
    check_eq({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    if (exp_we > 0) begin
      check_eq({tag, "_dm_din"}, wd, exp_val);
      check_eq({tag, "_dm_addr"}, {25'd0, wa}, {25'd0, a_i[8:2]});
    end else begin
      check_eq({tag, "_rdata"}, rdata, exp_val);
    end
    @(posedge clk); #1;
    check_eq({tag, "_pulse_end"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int dcnt, wcnt;
    rstn = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    #12;
    check_eq("rst_flags", {28'd0, busy, done, err, dm_we}, 32'd0);
    check_eq("rst_dm_addr", {25'd0, dm_addr}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_dm_din", dm_din, 32'd0);
    #4 rstn = 1'b1;   // t=16, just after a rising edge

    // Word store then word load.
    run("sw_040", 1'b1, 2'b10, 1'b0, 32'h040, 32'hDEADBEEF, 2, 1, 1'b0, 32'hDEADBEEF);
    check_eq("sw_040_mem", mem[16], 32'hDEADBEEF);
    run("lw_040", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 2, 0, 1'b0, 32'hDEADBEEF);

    // Byte store read-modify-write.
    preload(7'd16, 32'h11223344);
    run("sb_042", 1'b1, 2'b00, 1'b0, 32'h042, 32'h000000AB, 3, 1, 1'b0, 32'h11AB3344);
    check_eq("sb_042_mem", mem[16], 32'h11AB3344);

    // Load extension.
    preload(7'd16, 32'h80FF7F01);
    run("lb_042", 1'b0, 2'b00, 1'b0, 32'h042, 32'h0, 2, 0, 1'b0, 32'hFFFFFFFF);
    run("lbu_043", 1'b0, 2'b00, 1'b1, 32'h043, 32'h0, 2, 0, 1'b0, 32'h00000080);
    run("lh_040", 1'b0, 2'b01, 1'b0, 32'h040, 32'h0, 2, 0, 1'b0, 32'h00007F01);
    run("lhu_042", 1'b0, 2'b01, 1'b1, 32'h042, 32'h0, 2, 0, 1'b0, 32'h000080FF);
    run("lh_042", 1'b0, 2'b01, 1'b0, 32'h042, 32'h0, 2, 0, 1'b0, 32'hFFFF80FF);

    // Halfword store into the upper lane.
    run("sh_042", 1'b1, 2'b01, 1'b0, 32'h042, 32'hFFFF1234, 3, 1, 1'b0, 32'h12347F01);
    check_eq("sh_042_mem", mem[16], 32'h12347F01);

    // Rejected accesses leave rdata and memory alone.
    run("err_lh_041", 1'b0, 2'b01, 1'b0, 32'h041, 32'h0, 1, 0, 1'b1, 32'hFFFF80FF);
    preload(7'd0, 32'hCAFE0000);
    run("err_sw_200", 1'b1, 2'b10, 1'b0, 32'h200, 32'h01234567, 1, 0, 1'b1, 32'hFFFF80FF);
    check_eq("err_sw_200_mem", mem[0], 32'hCAFE0000);
    run("err_size11", 1'b0, 2'b11, 1'b0, 32'h040, 32'h0, 1, 0, 1'b1, 32'hFFFF80FF);

    // Request held high during RD of a load must be ignored.
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h040;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h000; wdata = 32'h99999999;
    dcnt = 0; wcnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (n == 1) req = 1'b0;
      if (done) dcnt++;
      if (dm_we) wcnt++;
      @(posedge clk); #1;
    end
    check_eq("busy_ign_done_cnt", dcnt, 1);
    check_eq("busy_ign_we_cnt", wcnt, 0);
    check_eq("busy_ign_rdata", rdata, 32'h12347F01);
    check_eq("busy_ign_idle", {31'd0, busy}, 32'd0);

    // Reset during WR.
    preload(7'd5, 32'h55AA55AA);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h014; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("rst_wr_we_before", {31'd0, dm_we}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_wr_we_after", {30'd0, dm_we, busy}, 32'd0);
    dcnt = 0;
    for (int n = 0; n < 3; n++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    check_eq("rst_wr_no_done", dcnt, 0);
    check_eq("rst_wr_rdata", rdata, 32'd0);
    rstn = 1'b1;
    run("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 2, 0, 1'b0, 32'h12347F01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
